// File: rtl/pucch_phase_seq.sv
// PUCCH format 1 per-subcarrier phase sequencer: ph(n) = cyc_part + base_ph[n] + 2*m*n (mod CYC_DIV),
// streamed over valid/ready. Optional macro PUCCH_PHASE_CONJ_EN adds conjugation (ph -> -ph mod CYC_DIV).
module pucch_phase_seq #(
  parameter int CYC_DIV = 24,
  parameter int N_SC    = 12,
  parameter int PW      = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [PW-1:0]     i_cyc_part,
  input  logic [3:0]        i_cs,
  input  logic [N_SC*PW-1:0] i_base_ph,
  input  logic              i_conj,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [PW-1:0]     o_ph,
  output logic [3:0]        o_sc,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PW:0] CYC_W   = (PW+1)'(CYC_DIV);
  localparam logic [3:0]  LAST_SC = 4'(N_SC - 1);
  localparam logic [4:0]  N_SC_W  = 5'(N_SC);

  // Modular add of two in-range operands: one extra bit, one conditional subtract.
  function automatic logic [PW-1:0] mod_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= CYC_W) s = s - CYC_W;
    return s[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] phase_of(input logic [PW-1:0] cyc, input logic [PW-1:0] base,
                                             input logic [PW-1:0] rot);
    return mod_add(mod_add(cyc, base), rot);
  endfunction

`ifdef PUCCH_PHASE_CONJ_EN
  function automatic logic [PW-1:0] conj_neg(input logic [PW-1:0] p, input logic en);
    logic [PW:0] d;
    d = CYC_W - {1'b0, p};
    if (!en || p == '0) return p;
    return d[PW-1:0];
  endfunction
`else
  logic unused_conj;
  assign unused_conj = i_conj;
`endif

  state_t              state_q;
  logic [PW-1:0]       cyc_q;
  logic [PW-1:0]       inc_q;
  logic [PW-1:0]       rot_q;
  logic [N_SC*PW-1:0]  base_q;
  logic                conj_q;
  logic                valid_q, last_q, busy_q, cfg_err_q;
  logic [3:0]          sc_q;
  logic [PW-1:0]       ph_q;

  logic                cs_ok;
  logic [PW:0]         two_m;
  logic [PW-1:0]       inc_d;
  logic [3:0]          sc_d;
  logic [PW-1:0]       rot_d;
  logic [PW-1:0]       ph_acc_d;
  logic [PW-1:0]       ph_run_d;

  always_comb begin
    cs_ok    = {1'b0, i_cs} < N_SC_W;
    two_m    = (PW+1)'({i_cs, 1'b0});
    if (two_m >= CYC_W) two_m = two_m - CYC_W;
    inc_d    = two_m[PW-1:0];
    sc_d     = sc_q + 4'd1;
    rot_d    = mod_add(rot_q, inc_q);
    ph_acc_d = phase_of(i_cyc_part, i_base_ph[PW-1:0], '0);
    ph_run_d = phase_of(cyc_q, base_q[int'(sc_d)*PW +: PW], rot_d);
`ifdef PUCCH_PHASE_CONJ_EN
    ph_acc_d = conj_neg(ph_acc_d, i_conj);
    ph_run_d = conj_neg(ph_run_d, conj_q);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      inc_q     <= '0;
      rot_q     <= '0;
      base_q    <= '0;
      conj_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      sc_q      <= '0;
      ph_q      <= '0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            if (cs_ok) begin
              state_q <= RUN;
              cyc_q   <= i_cyc_part;
              inc_q   <= inc_d;
              base_q  <= i_base_ph;
              conj_q  <= i_conj;
              rot_q   <= '0;
              sc_q    <= '0;
              ph_q    <= ph_acc_d;
              last_q  <= (LAST_SC == 4'd0);
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // Everything holds while the downstream stalls.
          if (valid_q && i_ready) begin
            if (last_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              sc_q   <= sc_d;
              rot_q  <= rot_d;
              ph_q   <= ph_run_d;
              last_q <= (sc_d == LAST_SC);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid   = valid_q;
  assign o_ph      = ph_q;
  assign o_sc      = sc_q;
  assign o_last    = last_q;
  assign o_busy    = busy_q;
  assign o_cfg_err = cfg_err_q;

endmodule
